// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear control FSM, gated prescaler and BCD
// mm:ss time counter for the Basys3 stopwatch display path.
// Optional build macro STOPWATCH_SAT_EN: saturate at 59:59 and force STOP
// instead of rolling over to 00:00.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        wrap
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    b_q, b_qq;          // {clear, start_stop, lap}
    logic          ev_clr, ev_ss, ev_lap;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   time_q, time_d;
    logic [15:0]   lap_q, lap_d;
    logic          sat_q, sat_d;
    logic          tick_d, wrap_d;
    logic [16:0]   inc;

    // BCD mm:ss increment with ripple carry; bit 16 flags the 59:59 rollover
    function automatic logic [16:0] bcd_inc(input logic [15:0] t);
        logic [3:0] so, st, mo, mt;
        logic       c;
        so = t[3:0];
        st = t[7:4];
        mo = t[11:8];
        mt = t[15:12];
        c  = 1'b0;
        if (so == 4'd9) begin
            so = 4'd0;
            if (st == 4'd5) begin
                st = 4'd0;
                if (mo == 4'd9) begin
                    mo = 4'd0;
                    if (mt == 4'd5) begin
                        mt = 4'd0;
                        c  = 1'b1;
                    end else begin
                        mt = mt + 4'd1;
                    end
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {c, mt, mo, st, so};
    endfunction

    // Rising-edge detect on the two-stage button history
    assign ev_clr = b_q[2] & ~b_qq[2];
    assign ev_ss  = b_q[1] & ~b_qq[1];
    assign ev_lap = b_q[0] & ~b_qq[0];

    // Next state, prescaler and time counter; clear > start_stop > lap
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        time_d  = time_q;
        lap_d   = lap_q;
        sat_d   = sat_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        inc     = bcd_inc(time_q);
        if (ev_clr) begin
            state_d = IDLE;
            pre_d   = '0;
            time_d  = '0;
            lap_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ev_ss) state_d = RUN;
                RUN: begin
                    if (ev_ss) begin
                        state_d = STOP;
                    end else if (ev_lap) begin
                        state_d = LAP;
                        lap_d   = time_q;
                    end
                end
                LAP: begin
                    if (ev_ss)       state_d = STOP;
                    else if (ev_lap) state_d = RUN;
                end
                STOP: if (ev_ss && !sat_q) state_d = RUN;
                default: state_d = IDLE;
            endcase
            // A pause landing on this edge freezes the prescaler, terminal count included
            if ((state_q == RUN || state_q == LAP) && state_d != STOP) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
`ifdef STOPWATCH_SAT_EN
                    if (inc[16]) begin
                        wrap_d  = 1'b1;
                        sat_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        time_d = inc[15:0];
                        tick_d = 1'b1;
                    end
`else
                    time_d = inc[15:0];
                    tick_d = 1'b1;
                    wrap_d = inc[16];
`endif
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        end
    end

    // State, counters, button history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            b_q        <= '0;
            b_qq       <= '0;
            pre_q      <= '0;
            time_q     <= '0;
            lap_q      <= '0;
            sat_q      <= 1'b0;
            disp_bcd   <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            tick       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= {btn_clear, btn_start_stop, btn_lap};
            b_qq       <= b_q;
            pre_q      <= pre_d;
            time_q     <= time_d;
            lap_q      <= lap_d;
            sat_q      <= sat_d;
            disp_bcd   <= (state_d == LAP) ? lap_d : time_d;
            running    <= (state_d == RUN) || (state_d == LAP);
            lap_active <= (state_d == LAP);
            tick       <= tick_d;
            wrap       <= wrap_d;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=10, TICK_HZ=1 (10 cycles per second).
module tb_stopwatch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] disp_bcd;
    logic        running, lap_active, tick, wrap;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk), .rst(rst), .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
        .btn_clear(btn_clear), .disp_bcd(disp_bcd), .running(running),
        .lap_active(lap_active), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL reset_disp got=%h exp=0000", disp_bcd); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL reset_lap got=%b exp=0", lap_active); end
        checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_tickwrap got=%b%b exp=00", tick, wrap); end
        rst = 1'b0;
        cyc(3);
        checks++; if (running !== 1'b0 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL idle_after_reset running=%b disp=%h exp 0/0000", running, disp_bcd); end
    endtask

    // Start, then 100 cycles: ticks at cycles 10,20,...,100 and 00:10 shown
    task automatic test_run;
        int nt, bad_gap, last;
        btn_start_stop = 1'b1;
        cyc(2);
        btn_start_stop = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_enter got=%b exp=1", running); end
        nt = 0; bad_gap = 0; last = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (tick === 1'b1) begin
                nt++;
                if (i - last != 10) bad_gap++;
                last = i;
            end
        end
        checks++; if (nt != 10) begin errors++; $display("FAIL run_tick_count got=%0d exp=10", nt); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL run_tick_spacing bad_gaps=%0d exp=0", bad_gap); end
        checks++; if (disp_bcd !== 16'h0010) begin errors++; $display("FAIL run_disp got=%h exp=0010", disp_bcd); end
    endtask

    // Pause with prescaler at 4, hold 30 cycles, resume: tick 6 cycles later
    task automatic test_pause;
        int moved, first;
        cyc(3);                     // prescaler 3 since the last tick
        btn_start_stop = 1'b1;
        cyc(2);                     // pause lands; prescaler frozen at 4
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b exp=0", running); end
        moved = 0;
        for (int i = 0; i < 28; i++) begin
            cyc();
            if (disp_bcd !== 16'h0010 || running !== 1'b0 || tick !== 1'b0) moved++;
        end
        checks++; if (moved != 0) begin errors++; $display("FAIL pause_frozen changed_cycles=%0d exp=0", moved); end
        btn_start_stop = 1'b0;
        cyc(2);
        btn_start_stop = 1'b1;
        cyc(2);
        btn_start_stop = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got=%b exp=1", running); end
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            cyc();
            if (tick === 1'b1) first = i;
        end
        checks++; if (first != 6) begin errors++; $display("FAIL resume_tick_latency got=%0d exp=6", first); end
        checks++; if (disp_bcd !== 16'h0011) begin errors++; $display("FAIL resume_disp got=%h exp=0011", disp_bcd); end
    endtask

    // Clear, run to 00:07, lap freezes display, second lap shows live 00:12
    task automatic test_lap;
        btn_clear = 1'b1;
        cyc(2);
        btn_clear = 1'b0;
        checks++; if (running !== 1'b0 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL lap_pre_clear running=%b disp=%h exp 0/0000", running, disp_bcd); end
        cyc(2);
        btn_start_stop = 1'b1;
        cyc(2);
        btn_start_stop = 1'b0;
        cyc(70);
        checks++; if (disp_bcd !== 16'h0007) begin errors++; $display("FAIL lap_at7 got=%h exp=0007", disp_bcd); end
        btn_lap = 1'b1;
        cyc(2);
        btn_lap = 1'b0;
        checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL lap_enter got=%b exp=1", lap_active); end
        cyc(50);
        checks++; if (disp_bcd !== 16'h0007) begin errors++; $display("FAIL lap_frozen got=%h exp=0007", disp_bcd); end
        checks++; if (lap_active !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL lap_status lap=%b run=%b exp 1/1", lap_active, running); end
        btn_lap = 1'b1;
        cyc(2);
        btn_lap = 1'b0;
        checks++; if (disp_bcd !== 16'h0012) begin errors++; $display("FAIL lap_live got=%h exp=0012", disp_bcd); end
        checks++; if (lap_active !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL lap_exit lap=%b run=%b exp 0/1", lap_active, running); end
    endtask

    // Clear and start_stop together in RUN: clear wins, start_stop dropped
    task automatic test_clear_priority;
        int nt, runs;
        btn_clear = 1'b1;
        btn_start_stop = 1'b1;
        cyc(2);
        btn_clear = 1'b0;
        btn_start_stop = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clr_running got=%b exp=0", running); end
        checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL clr_disp got=%h exp=0000", disp_bcd); end
        nt = 0; runs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick === 1'b1) nt++;
            if (running !== 1'b0) runs++;
        end
        checks++; if (nt != 0) begin errors++; $display("FAIL clr_no_tick got=%0d exp=0", nt); end
        checks++; if (runs != 0) begin errors++; $display("FAIL clr_stays_idle running_cycles=%0d exp=0", runs); end
    endtask

    // Run to 59:58, then 20 more cycles across the rollover
    task automatic test_wrap;
        int nt, nw, wpos;
        btn_start_stop = 1'b1;
        cyc(2);
        btn_start_stop = 1'b0;
        cyc(35980);
        checks++; if (disp_bcd !== 16'h5958) begin errors++; $display("FAIL wrap_preload got=%h exp=5958", disp_bcd); end
        nt = 0; nw = 0; wpos = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (tick === 1'b1) nt++;
            if (wrap === 1'b1) begin nw++; wpos = i; end
        end
        checks++; if (nw != 1 || wpos != 20) begin errors++; $display("FAIL wrap_pulse count=%0d at=%0d exp 1 at 20", nw, wpos); end
`ifdef STOPWATCH_SAT_EN
        checks++; if (nt != 1) begin errors++; $display("FAIL sat_tick_count got=%0d exp=1", nt); end
        checks++; if (disp_bcd !== 16'h5959 || running !== 1'b0) begin errors++; $display("FAIL sat_hold disp=%h run=%b exp 5959/0", disp_bcd, running); end
        btn_start_stop = 1'b1;
        cyc(4);
        btn_start_stop = 1'b0;
        checks++; if (disp_bcd !== 16'h5959 || running !== 1'b0) begin errors++; $display("FAIL sat_ignore_start disp=%h run=%b exp 5959/0", disp_bcd, running); end
`else
        checks++; if (nt != 2) begin errors++; $display("FAIL wrap_tick_count got=%0d exp=2", nt); end
        checks++; if (disp_bcd !== 16'h0000 || running !== 1'b1) begin errors++; $display("FAIL wrap_rollover disp=%h run=%b exp 0000/1", disp_bcd, running); end
`endif
    endtask

    // Clear, then hold start_stop 200 cycles: exactly one change of running
    task automatic test_hold;
        int changes;
        logic prev;
        btn_clear = 1'b1;
        cyc(2);
        btn_clear = 1'b0;
        cyc(2);
        prev = running;
        changes = 0;
        btn_start_stop = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (running !== prev) changes++;
            prev = running;
        end
        btn_start_stop = 1'b0;
        checks++; if (changes != 1) begin errors++; $display("FAIL hold_one_event changes=%0d exp=1", changes); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL hold_running got=%b exp=1", running); end
    endtask

    // Synchronous reset in RUN zeroes every output on the next edge
    task automatic test_reset_mid_run;
        cyc(5);
        rst = 1'b1;
        cyc();
        checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL rst_run_disp got=%h exp=0000", disp_bcd); end
        checks++; if (running !== 1'b0 || lap_active !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL rst_run_flags got=%b%b%b%b exp=0000", running, lap_active, tick, wrap);
        end
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_lap();
        test_clear_priority();
        test_wrap();
        test_hold();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
